// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner.
// REPEAT_* constants are only consumed when KEYPAD_REPEAT_EN is defined.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_PRESS,
    PRESSED,
    DEBOUNCE_RELEASE
  } state_t;

  // Indexed [row][col]; row0 is the top row, col0 the leftmost column.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  localparam int REPEAT_DELAY_TICKS = 6_000_000;
  localparam int REPEAT_TICKS       = 1_200_000;
  localparam int COL_SETTLE         = 2;

  // One-cold column drive for column index c.
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    col_drive = ~(4'b0001 << c);
  endfunction

  // Lowest-index active-low row wins when several rows read low.
  function automatic logic [1:0] first_low_row(input logic [3:0] r);
    first_low_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) first_low_row = 2'(i);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer with async active-low reset.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, two-digit history.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 12_000,
  parameter int DEBOUNCE_TICKS = 240_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  logic [3:0]    rows_s;
  logic          rows_idle;
  state_t        state;
  logic [1:0]    col;
  logic [1:0]    col_nxt;
  logic [1:0]    cand_col;
  logic [3:0]    cand_rows;
  logic [3:0]    cand_code;
  logic [CW-1:0] cnt;

  // Rows idle high through the pull-ups, so the synchronizer resets to all-ones.
  sync_2ff #(
    .W       (4),
    .RST_VAL (4'hF)
  ) u_rows_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rows),
    .q       (rows_s)
  );

  assign rows_idle = (rows_s == 4'hF);
  assign col_nxt   = col + 2'd1;
  assign cand_code = KEY_MAP[first_low_row(cand_rows)][cand_col];

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_TICKS + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
  logic [RW-1:0] rpt_limit;

  assign rpt_limit = rpt_first ? RW'(REPEAT_DELAY_TICKS - 1) : RW'(REPEAT_TICKS - 1);
`endif

  // cnt is shared: column dwell time in SCAN, matching run length in the debounce states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCAN;
      col       <= 2'd0;
      cols      <= 4'b1110;
      cand_col  <= 2'd0;
      cand_rows <= 4'hF;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          // rows_s lags cols by the synchronizer depth; wait it out before trusting rows.
          if (!rows_idle && cnt >= CW'(COL_SETTLE)) begin
            cand_col  <= col;
            cand_rows <= rows_s;
            cnt       <= '0;
            state     <= DEBOUNCE_PRESS;
          end else if (cnt == CW'(SCAN_TICKS - 1)) begin
            col  <= col_nxt;
            cols <= col_drive(col_nxt);
            cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DEBOUNCE_PRESS: begin
          if (rows_s != cand_rows) begin
            col   <= col_nxt;
            cols  <= col_drive(col_nxt);
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
            key_code  <= cand_code;
            key_valid <= 1'b1;
            digit_old <= digit_new;
            digit_new <= cand_code;
            key_held  <= 1'b1;
            cnt       <= '0;
            state     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        PRESSED: begin
          if (rows_idle) begin
            cnt   <= '0;
            state <= DEBOUNCE_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rpt_cnt == rpt_limit) begin
            key_valid <= 1'b1;
            digit_old <= digit_new;
            digit_new <= key_code;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
          end
`endif
        end

        DEBOUNCE_RELEASE: begin
          if (!rows_idle) begin
            cnt   <= '0;
            state <= PRESSED;
          end else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
            key_held <= 1'b0;
            col      <= col_nxt;
            cols     <= col_drive(col_nxt);
            cnt      <= '0;
            state    <= SCAN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule
